// File: rtl/primo_prefetch.sv
// Prefetcher for primogen: drives its go/ready handshake and queues successive
// primes in a small FIFO presented as a valid/ready stream.
module primo_prefetch #(
   parameter int WIDTH    = 16,
   parameter int DEPTH    = 4,
   parameter int SKIP_ONE = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   output logic                       gen_go,
   input  logic                       gen_ready,
   input  logic                       gen_error,
   input  logic [WIDTH-1:0]           gen_res,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic                       out_error,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   typedef enum logic [1:0] {
      S_WAIT_RDY,
      S_ISSUE,
      S_WAIT_LOW,
      S_ERR
   } state_t;

   state_t          state_q, state_d;
   logic            first_q, first_d;
   logic            err_q, err_d;
   logic            out_error_q;
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic            push, pop;

   // NOTE: every signal written here gets a default first, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      first_d = first_q;
      err_d   = err_q;
      push    = 1'b0;
      gen_go  = 1'b0;
      unique case (state_q)
         S_WAIT_RDY: begin
            if (gen_ready) begin
               if (gen_error) begin
                  state_d = S_ERR;
                  err_d   = 1'b1;
               end else begin
                  // Room is guaranteed: go is only issued while not full.
                  push    = !(first_q && (SKIP_ONE != 0));
                  first_d = 1'b0;
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            if (count_q < CW'(DEPTH)) begin
               gen_go  = 1'b1;
               state_d = S_WAIT_LOW;
            end
         end
         S_WAIT_LOW: begin
            // Wait for the stale result to drop before listening for the next.
            if (!gen_ready) state_d = S_WAIT_RDY;
         end
         S_ERR: ;
         default: state_d = S_WAIT_RDY;
      endcase
   end

   assign pop = (count_q != '0) && out_ready;

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_WAIT_RDY;
         first_q     <= 1'b1;
         err_q       <= 1'b0;
         out_error_q <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         first_q     <= first_d;
         err_q       <= err_d;
         out_error_q <= err_q && (count_q == '0);
         count_q     <= count_d;
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      end
   end

   // NOTE: the storage array is deliberately not reset; occupancy alone says
   // which entries are meaningful, and the head is masked while empty.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= gen_res;
   end

   assign out_valid = (count_q != '0);
   assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
   assign out_error = out_error_q;
   assign count     = count_q;

endmodule
